adc_rd_streamer: RTL and testbench

- Readout stage feeding the ADC_DATA pad group (18 data bits + DATA_VALID) in the readout clock domain.
- On a configuration start pulse (from the MDIO register bank), reads N captured samples from the capture buffer, starting at a base address.
- Presents the samples on the pad-side output register, one sample per programmable pacing period.
- Consumes the capture buffer's synchronous read port; produces the signals driven to PAD1..PAD19.

---
 rtl/adc_rd_streamer.sv | 173 +++++++++++++++++
 tb/tb_adc_rd_streamer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_rd_streamer.sv
// adc_rd_streamer: streams N samples out of the capture buffer onto the ADC_DATA pad group.
//
// A start pulse latches base address, length and pacing. Reads are issued once per pacing
// period of P = cfg_div + 1 cycles. Each sample is registered onto the pad-side output two
// cycles after its read, together with a one-cycle valid strobe.
//
// Ports
//   clk_rd_i          readout clock
//   rstn_i            synchronous active-low reset
//   cfg_start_i       one-cycle start pulse, accepted in IDLE only
//   cfg_abort_i       one-cycle abort pulse, honoured while a run is in progress
//   cfg_base_addr_i   first buffer address
//   cfg_len_i         number of samples (0 = immediate done)
//   cfg_div_i         pacing divider
//   buf_rd_en_o       capture buffer read enable
//   buf_rd_addr_o     capture buffer read address
//   buf_rd_data_i     capture buffer read data, one cycle after the enable
//   adc_data_o        registered sample to the pads (held between strobes)
//   adc_data_valid_o  one-cycle strobe per sample
//   busy_o            run in progress
//   done_o            one-cycle pulse on normal completion
//   aborted_o         sticky abort flag, cleared by the next accepted start
//   sample_cnt_o      samples emitted in the current or last run
module adc_rd_streamer #(
    parameter int unsigned DW   = 18,
    parameter int unsigned AW   = 14,
    parameter int unsigned DIVW = 8
) (
    input  logic            clk_rd_i,
    input  logic            rstn_i,
    input  logic            cfg_start_i,
    input  logic            cfg_abort_i,
    input  logic [AW-1:0]   cfg_base_addr_i,
    input  logic [AW:0]     cfg_len_i,
    input  logic [DIVW-1:0] cfg_div_i,
    output logic            buf_rd_en_o,
    output logic [AW-1:0]   buf_rd_addr_o,
    input  logic [DW-1:0]   buf_rd_data_i,
    output logic [DW-1:0]   adc_data_o,
    output logic            adc_data_valid_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            aborted_o,
    output logic [AW:0]     sample_cnt_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q;
    logic [AW-1:0]   base_q;
    logic [AW:0]     len_q;
    logic [DIVW-1:0] div_q;
    logic [AW:0]     rd_cnt_q;    // reads issued so far in this run
    logic [DIVW-1:0] pace_q;      // cycles left before the next read
    logic            pend_q;      // read data is on buf_rd_data_i this cycle
    logic            rd_en_q;
    logic [AW-1:0]   rd_addr_q;
    logic [DW-1:0]   adc_data_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;
    logic            aborted_q;
    logic [AW:0]     sample_cnt_q;

    logic [AW:0]     rd_cnt_nxt;
    logic [AW-1:0]   rd_addr_nxt;

    always_comb begin
        rd_cnt_nxt  = rd_cnt_q + (AW+1)'(1);
        // Adder is AW bits wide so the address wraps at the top of the buffer.
        rd_addr_nxt = base_q + rd_cnt_q[AW-1:0];
    end

    always_ff @(posedge clk_rd_i) begin
        if (!rstn_i) begin
            state_q      <= StIdle;
            base_q       <= '0;
            len_q        <= '0;
            div_q        <= '0;
            rd_cnt_q     <= '0;
            pace_q       <= '0;
            pend_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            adc_data_q   <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= rd_en_q;

            // Capture stage; an abort below overrides it to discard the in-flight read.
            if (pend_q) begin
                adc_data_q   <= buf_rd_data_i;
                valid_q      <= 1'b1;
                sample_cnt_q <= sample_cnt_q + (AW+1)'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (cfg_start_i) begin
                        sample_cnt_q <= '0;
                        if (cfg_len_i != '0) begin
                            base_q    <= cfg_base_addr_i;
                            len_q     <= cfg_len_i;
                            div_q     <= cfg_div_i;
                            aborted_q <= 1'b0;
                            busy_q    <= 1'b1;
                            // Read 0 goes out in the first busy cycle.
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= cfg_base_addr_i;
                            rd_cnt_q  <= (AW+1)'(1);
                            pace_q    <= cfg_div_i;
                            state_q   <= (cfg_len_i == (AW+1)'(1)) ? StDrain : StRun;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StRun, StDrain: begin
                    if (cfg_abort_i) begin
                        state_q      <= StIdle;
                        busy_q       <= 1'b0;
                        aborted_q    <= 1'b1;
                        pend_q       <= 1'b0;
                        valid_q      <= 1'b0;
                        adc_data_q   <= adc_data_q;
                        sample_cnt_q <= sample_cnt_q;
                    end else if (state_q == StRun) begin
                        if (pace_q == '0) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= rd_addr_nxt;
                            rd_cnt_q  <= rd_cnt_nxt;
                            pace_q    <= div_q;
                            if (rd_cnt_nxt == len_q) begin
                                state_q <= StDrain;
                            end
                        end else begin
                            pace_q <= pace_q - DIVW'(1);
                        end
                    end else if (valid_q && !pend_q && !rd_en_q) begin
                        // Last sample is on the pads now; completion is the cycle after.
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign buf_rd_en_o      = rd_en_q;
    assign buf_rd_addr_o    = rd_addr_q;
    assign adc_data_o       = adc_data_q;
    assign adc_data_valid_o = valid_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign aborted_o        = aborted_q;
    assign sample_cnt_o     = sample_cnt_q;

endmodule

// File: tb/tb_adc_rd_streamer.sv
// Scoreboard bench for adc_rd_streamer: the stimulus side predicts every read, sample strobe
// and done pulse (with its cycle) from the timing rules and pushes them into queues; a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_adc_rd_streamer;

    localparam int DW    = 18;
    localparam int AW    = 14;
    localparam int DIVW  = 8;
    localparam int DEPTH = 1 << AW;

    logic            clk_rd = 1'b0;
    logic            rstn;
    logic            cfg_start;
    logic            cfg_abort;
    logic [AW-1:0]   cfg_base_addr;
    logic [AW:0]     cfg_len;
    logic [DIVW-1:0] cfg_div;
    logic            buf_rd_en;
    logic [AW-1:0]   buf_rd_addr;
    logic [DW-1:0]   buf_rd_data;
    logic [DW-1:0]   adc_data;
    logic            adc_data_valid;
    logic            busy;
    logic            done;
    logic            aborted;
    logic [AW:0]     sample_cnt;

    always #5 clk_rd = ~clk_rd;

    adc_rd_streamer #(.DW(DW), .AW(AW), .DIVW(DIVW)) dut (
        .clk_rd_i        (clk_rd),
        .rstn_i          (rstn),
        .cfg_start_i     (cfg_start),
        .cfg_abort_i     (cfg_abort),
        .cfg_base_addr_i (cfg_base_addr),
        .cfg_len_i       (cfg_len),
        .cfg_div_i       (cfg_div),
        .buf_rd_en_o     (buf_rd_en),
        .buf_rd_addr_o   (buf_rd_addr),
        .buf_rd_data_i   (buf_rd_data),
        .adc_data_o      (adc_data),
        .adc_data_valid_o(adc_data_valid),
        .busy_o          (busy),
        .done_o          (done),
        .aborted_o       (aborted),
        .sample_cnt_o    (sample_cnt)
    );

    // Capture buffer: synchronous read port.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk_rd) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

    int cyc = 0;
    always @(posedge clk_rd) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
        int cnt;
    } ev_t;

    ev_t rdq[$];
    ev_t vq[$];
    int  doneq[$];
    int  busy_lo = 1;
    int  busy_hi = 0;
    int  exp_hold = 0;
    int  exp_cnt = 0;
    bit  exp_ab = 1'b0;
    bit  mon_en = 1'b0;
    logic rstn_prev = 1'b1;
    ev_t mon_e;
    int  mon_d;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got a pulse, expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor
    always @(negedge clk_rd) begin
        if (mon_en) begin
            if (!rstn_prev) exp_hold = 0;
            if (adc_data_valid) begin
                if (vq.size() == 0) unexpected("adc_data_valid");
                else begin
                    mon_e = vq.pop_front();
                    check("valid_cycle", cyc, mon_e.cyc);
                    check("adc_data", 32'(adc_data), mon_e.val);
                    check("sample_cnt", 32'(sample_cnt), mon_e.cnt);
                    exp_hold = mon_e.val;
                end
            end else begin
                check("adc_data_hold", 32'(adc_data), exp_hold);
            end
            if (buf_rd_en) begin
                if (rdq.size() == 0) unexpected("buf_rd_en");
                else begin
                    mon_e = rdq.pop_front();
                    check("read_cycle", cyc, mon_e.cyc);
                    check("buf_rd_addr", 32'(buf_rd_addr), mon_e.val);
                end
            end
            if (done) begin
                if (doneq.size() == 0) unexpected("done");
                else begin
                    mon_d = doneq.pop_front();
                    check("done_cycle", cyc, mon_d);
                end
            end
            check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
        end
        rstn_prev = rstn;
    end

    task automatic tick;
        @(posedge clk_rd);
        #1;
    endtask

    task automatic prune(input int a);
        while (rdq.size() > 0 && rdq[rdq.size()-1].cyc > a) void'(rdq.pop_back());
        while (vq.size() > 0 && vq[vq.size()-1].cyc > a) void'(vq.pop_back());
        while (doneq.size() > 0 && doneq[doneq.size()-1] > a) void'(doneq.pop_back());
    endtask

    // One run. Offsets are cycles after the accept cycle T; 0 disables the event.
    task automatic run(input int base, input int len, input int div, input int abort_off,
                       input int istart_off, input int rst_off, input bit abort_with_start);
        int t;
        int p;
        int endc;
        int addr;
        bit in_rst;
        cfg_start     = 1'b1;
        cfg_abort     = abort_with_start;
        cfg_base_addr = AW'(base);
        cfg_len       = (AW+1)'(len);
        cfg_div       = DIVW'(div);
        t = cyc;
        p = div + 1;
        for (int k = 0; k < len; k++) begin
            addr = (base + k) % DEPTH;
            rdq.push_back('{t + 1 + k * p, addr, 0});
            vq.push_back('{t + 3 + k * p, int'(mem[addr]), k + 1});
        end
        if (len == 0) begin
            endc = t + 1;
        end else begin
            endc    = t + 4 + (len - 1) * p;
            busy_lo = t + 1;
            busy_hi = t + 3 + (len - 1) * p;
            exp_ab  = 1'b0;
        end
        doneq.push_back(endc);
        exp_cnt = len;
        tick;
        cfg_start     = 1'b0;
        cfg_abort     = 1'b0;
        cfg_base_addr = AW'($urandom);
        cfg_len       = (AW+1)'($urandom_range(1, 40));
        cfg_div       = DIVW'($urandom);
        in_rst        = 1'b0;
        while (cyc <= endc + 2) begin
            if (istart_off > 0 && cyc == t + istart_off) begin
                cfg_start = 1'b1;
            end
            if (abort_off > 0 && cyc == t + abort_off) begin
                cfg_abort = 1'b1;
                exp_cnt = 0;
                for (int k = 0; k < len; k++) if (t + 3 + k * p <= cyc) exp_cnt++;
                prune(cyc);
                busy_hi = cyc;
                endc    = cyc + 1;
                exp_ab  = 1'b1;
            end
            if (rst_off > 0 && cyc == t + rst_off) begin
                rstn = 1'b0;
                prune(cyc);
                busy_hi = cyc;
                endc    = cyc + 1;
                exp_ab  = 1'b0;
                exp_cnt = 0;
                in_rst  = 1'b1;
            end
            tick;
            cfg_start = 1'b0;
            cfg_abort = 1'b0;
            if (in_rst) begin
                check("rst_sample_cnt", 32'(sample_cnt), 0);
                check("rst_aborted", 32'(aborted), 0);
                check("rst_adc_data", 32'(adc_data), 0);
                check("rst_valid", 32'(adc_data_valid), 0);
                check("rst_rd_en", 32'(buf_rd_en), 0);
                check("rst_done", 32'(done), 0);
                rstn   = 1'b1;
                in_rst = 1'b0;
            end
        end
        check("rdq_left", rdq.size(), 0);
        check("vq_left", vq.size(), 0);
        check("doneq_left", doneq.size(), 0);
        rdq.delete();
        vq.delete();
        doneq.delete();
        check("end_sample_cnt", 32'(sample_cnt), exp_cnt);
        check("end_aborted", 32'(aborted), 32'(exp_ab));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int len;
        int div;
        int span;
        int ab;
        int ist;
        for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a) ^ 18'h2AAAA;
        rstn          = 1'b0;
        cfg_start     = 1'b0;
        cfg_abort     = 1'b0;
        cfg_base_addr = '0;
        cfg_len       = '0;
        cfg_div       = '0;
        repeat (3) tick;
        check("reset_rd_en", 32'(buf_rd_en), 0);
        check("reset_rd_addr", 32'(buf_rd_addr), 0);
        check("reset_adc_data", 32'(adc_data), 0);
        check("reset_valid", 32'(adc_data_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_aborted", 32'(aborted), 0);
        check("reset_sample_cnt", 32'(sample_cnt), 0);
        rstn   = 1'b1;
        mon_en = 1'b1;
        tick;

        run(16'h0010, 4, 0, 0, 0, 0, 1'b0);   // basic back-to-back stream
        tick;
        run(16'h0100, 3, 2, 0, 0, 0, 1'b0);   // paced
        tick;
        run(16'h3FFE, 4, 0, 0, 0, 0, 1'b0);   // address wrap
        run(16'h3FFF, 3, 1, 0, 0, 0, 1'b1);   // start with abort in IDLE: start wins
        tick;
        run(16'h0055, 0, 3, 0, 0, 0, 1'b0);   // zero length
        tick;
        cfg_abort = 1'b1;                     // abort while idle: no effect
        tick;
        cfg_abort = 1'b0;
        tick;
        check("idle_abort_aborted", 32'(aborted), 0);
        run(16'h0200, 10, 0, 5, 2, 0, 1'b0);  // abort at T+5, ignored start at T+2
        tick;
        run(16'h0300, 6, 0, 0, 0, 4, 1'b0);   // reset at T+4
        tick;
        run(16'h0300, 6, 0, 0, 0, 0, 1'b0);   // fresh run after reset
        tick;

        for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom);
        for (int i = 0; i < 24; i++) begin
            base = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 6, DEPTH - 1)
                                                : $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(1, 12);
            div  = $urandom_range(0, 4);
            span = 3 + (len - 1) * (div + 1);
            ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, span) : 0;
            ist  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (ab > 0) ? ab : span) : 0;
            run(base, len, div, ab, ist, 0, 1'(($urandom_range(0, 3) == 0)));
            repeat ($urandom_range(0, 2)) tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
